// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude Q-format divider:
// FSM state encoding and the saturated-magnitude helper.
package qdiv_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } qdiv_state_e;

    // Largest magnitude representable in an n-bit sign-magnitude word.
    function automatic int unsigned max_mag(input int unsigned n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/qdiv_seq_if.sv
// Start/busy/done handshake and operand/result bundle for qdiv_seq.
interface qdiv_seq_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic         overflow;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, overflow, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, overflow, div_zero
    );
endinterface

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude fixed-point divider: restoring shift-subtract,
// one quotient bit per clock, saturating result with overflow/div-by-zero flags.
module qdiv_seq
    import qdiv_seq_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned Q = 2
) (
    input logic       clk,
    input logic       rst_n,
    qdiv_seq_if.slave bus
);
    localparam int unsigned M  = N - 1;
    localparam int unsigned W  = M + Q;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [M-1:0] MaxMag = M'(max_mag(N));
    localparam logic [W:0]   SatLim = (W + 1)'(1) << M;

    qdiv_state_e state_q, state_d;
    logic          sign_q, sign_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  rem_q, rem_d;
    logic [W-1:0]  num_q, num_d;
    logic [W-1:0]  qm_q, qm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic          overflow_q, overflow_d;
    logic          div_zero_q, div_zero_d;

    logic [M:0]    rem_shift;
    logic [M-1:0]  rem_diff;
    logic          rem_ge;
    logic [W-1:0]  qm_next;
    logic          sat;
    logic [M-1:0]  mag;

    // Remainder stays below B, so the shifted value fits in M+1 bits.
    assign rem_shift = {rem_q, num_q[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, b_q};
    assign rem_diff  = rem_shift[M-1:0] - b_q;
    assign qm_next   = (qm_q << 1) | W'(rem_ge);
    assign sat       = {1'b0, qm_next} >= SatLim;
    assign mag       = sat ? MaxMag : qm_next[M-1:0];

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        b_d        = b_q;
        rem_d      = rem_q;
        num_d      = num_q;
        qm_d       = qm_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sign_d = bus.dividend[N-1] ^ bus.divisor[N-1];
                    b_d    = bus.divisor[M-1:0];
                    num_d  = W'(bus.dividend[M-1:0]) << Q;
                    rem_d  = '0;
                    qm_d   = '0;
                    if (bus.divisor[M-1:0] == '0) begin
                        state_d    = StDone;
                        quotient_d = {bus.dividend[N-1] ^ bus.divisor[N-1], MaxMag};
                        overflow_d = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = CW'(W);
                    end
                end
            end
            StRun: begin
                rem_d = rem_ge ? rem_diff : rem_shift[M-1:0];
                qm_d  = qm_next;
                num_d = num_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = StDone;
                    quotient_d = {sign_q & (mag != '0), mag};
                    overflow_d = sat;
                    div_zero_d = 1'b0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            b_q        <= '0;
            rem_q      <= '0;
            num_q      <= '0;
            qm_q       <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            num_q      <= num_d;
            qm_q       <= qm_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            overflow_q <= overflow_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = state_q != StIdle;
    assign bus.done     = state_q == StDone;
    assign bus.quotient = quotient_q;
    assign bus.overflow = overflow_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Scoreboard bench for qdiv_seq: stimulus pushes reference results, a monitor
// pops and compares them whenever done is seen.
module tb_qdiv_seq;
    localparam int N = 4;
    localparam int Q = 2;

    typedef struct {
        logic [N-1:0] dd;
        logic [N-1:0] dv;
        logic [N-1:0] q;
        logic         ov;
        logic         dz;
        int           done_cyc;
        int           spacing;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qdiv_seq_if #(.N(N)) bus ();
    qdiv_seq #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           last_done = -1;
    logic [N-1:0] last_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Reference: truncating sign-magnitude division with saturation.
    function automatic exp_t model(input logic [N-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        int   a, b, m, maxm;
        logic s;
        maxm = (1 << (N - 1)) - 1;
        a = int'(dd) & maxm;
        b = int'(dv) & maxm;
        e.dd = dd; e.dv = dv; e.ov = 1'b0; e.dz = 1'b0;
        if (b == 0) begin
            m = maxm; e.ov = 1'b1; e.dz = 1'b1;
        end else begin
            m = (a * (1 << Q)) / b;
            if (m > maxm) begin m = maxm; e.ov = 1'b1; end
        end
        s = dd[N-1] ^ dv[N-1];
        if (m == 0) s = 1'b0;
        e.q = {s, 3'(m)};
        e.done_cyc = cyc + ((b == 0) ? 1 : N + Q);
        e.spacing = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("quotient %b/%b", e.dd, e.dv), int'(bus.quotient), int'(e.q));
                check($sformatf("overflow %b/%b", e.dd, e.dv), int'(bus.overflow), int'(e.ov));
                check($sformatf("div_zero %b/%b", e.dd, e.dv), int'(bus.div_zero), int'(e.dz));
                check($sformatf("latency %b/%b", e.dd, e.dv), cyc, e.done_cyc);
                if (e.spacing > 0) check("done_spacing", cyc - last_done, e.spacing);
                last_q = e.q;
            end
            last_done = cyc;
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv);
        wait_idle();
        bus.start = 1'b1;
        bus.dividend = dd;
        bus.divisor = dv;
        sb.push_back(model(dd, dv));
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = $urandom_range(0, 15);
        bus.divisor = $urandom_range(0, 15);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_quotient"}, int'(bus.quotient), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
        check({tag, "_div_zero"}, int'(bus.div_zero), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        issue(4'b0010, 4'b0100);
        issue(4'b1011, 4'b0010);
        issue(4'b0001, 4'b0011);
        issue(4'b0100, 4'b0010);
        issue(4'b1100, 4'b0000);
        issue(4'b0000, 4'b0101);
        drain();
        repeat (3) @(negedge clk);
        check("held_quotient", int'(bus.quotient), int'(last_q));

        // start re-pulsed with new operands mid-RUN must be ignored
        issue(4'b1000, 4'b1001);
        bus.start = 1'b1;
        bus.dividend = 4'b0111;
        bus.divisor = 4'b0001;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // asynchronous reset on the third RUN cycle
        issue(4'b0110, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        sb.delete();
        last_done = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0010, 4'b0100);
        drain();

        // random operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        drain();

        // exhaustive sweep with start held high
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            if (i > 0) wait_idle();
            bus.dividend = 4'(i >> 4);
            bus.divisor = 4'(i);
            e = model(bus.dividend, bus.divisor);
            if (i > 0) e.spacing = e.done_cyc - cyc + 1;
            sb.push_back(e);
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
